// File: rtl/esram_rd_sched.sv
// esram_rd_sched: eSRAM read scheduler with credit-based admission and an in-order response FIFO.
// Optional build macro ESRAM_RD_ALIGN_CHECK_EN adds the sticky align_err output.
// Ports: clk_esram/rst (sync, active high); esram_pll_lock gates admission;
//   req_* valid/ready read requests in; rden/rdaddress to memory; rd_valid/rddata from memory;
//   rsp_* valid/ready responses out with their metadata; credits = free response slots.
module esram_rd_sched #(
  parameter int AWIDTH     = 17,
  parameter int DWIDTH     = 520,
  parameter int MWIDTH     = 16,
  parameter int RD_LAT     = 12,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                          clk_esram,
  input  logic                          rst,
  input  logic                          esram_pll_lock,
  input  logic [AWIDTH-1:0]             req_addr,
  input  logic [MWIDTH-1:0]             req_meta,
  input  logic                          req_valid,
  output logic                          req_ready,
  output logic                          rden,
  output logic [AWIDTH-1:0]             rdaddress,
  input  logic                          rd_valid,
  input  logic [DWIDTH-1:0]             rddata,
  output logic [DWIDTH-1:0]             rsp_data,
  output logic [MWIDTH-1:0]             rsp_meta,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
`ifdef ESRAM_RD_ALIGN_CHECK_EN
  output logic                          align_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   credits
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(RD_LAT + 1);
  logic              accept, push, pop;
  logic [MWIDTH-1:0] meta_q;
  logic [MWIDTH-1:0] dl_m [RD_LAT];
  logic [LW-1:0]     drain;
  logic [PW:0]       wptr, rptr;
  logic [DWIDTH+MWIDTH-1:0] mem [FIFO_DEPTH];
  // Requests are held off during reset so nothing is issued before state is cleared.
  assign req_ready = esram_pll_lock & (credits != '0) & ~rst;
  assign accept    = req_valid & req_ready;
  assign rsp_valid = wptr != rptr;
  assign pop       = rsp_valid & rsp_ready;
  assign {rsp_data, rsp_meta} = mem[rptr[PW-1:0]];
`ifdef ESRAM_RD_ALIGN_CHECK_EN
  logic [RD_LAT-1:0] dl_v;
  assign push = dl_v[RD_LAT-1] & (drain == '0);
  always_ff @(posedge clk_esram)
    if (rst) begin
      dl_v      <= '0;
      align_err <= 1'b0;
    end else begin
      dl_v <= {dl_v[RD_LAT-2:0], rden};
      if (drain == '0 && rd_valid != dl_v[RD_LAT-1]) align_err <= 1'b1;
    end
`else
  assign push = rd_valid & (drain == '0);
`endif
  always_ff @(posedge clk_esram)
    if (rst) begin
      rden      <= 1'b0;
      rdaddress <= '0;
      meta_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) dl_m[i] <= '0;
    end else begin
      rden  <= accept;
      dl_m[0] <= meta_q;
      for (int i = 1; i < RD_LAT; i++) dl_m[i] <= dl_m[i-1];
      if (accept) begin
        rdaddress <= req_addr;
        meta_q    <= req_meta;
      end
    end
  // Returns from reads issued before reset land inside this window and are discarded.
  always_ff @(posedge clk_esram)
    drain <= rst ? LW'(RD_LAT) : drain - LW'(drain != '0);
  always_ff @(posedge clk_esram)
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      credits <= CW'(FIFO_DEPTH);
    end else begin
      wptr    <= wptr + (PW+1)'(push);
      rptr    <= rptr + (PW+1)'(pop);
      credits <= credits + CW'(pop) - CW'(accept);
    end
  always_ff @(posedge clk_esram)
    if (push) mem[wptr[PW-1:0]] <= {rddata, dl_m[RD_LAT-1]};
endmodule

// File: tb/tb_esram_rd_sched.sv
// tb_esram_rd_sched: randomized and directed bench against a queue-based reference model.
module tb_esram_rd_sched;
  localparam int AW = 17, DW = 520, MW = 16, LAT = 12, DEPTH = 32, CW = 6;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, lock, req_valid, req_ready, rden, rd_valid, rsp_valid, rsp_ready, inject;
  logic [AW-1:0] req_addr, rdaddress;
  logic [MW-1:0] req_meta, rsp_meta;
  logic [DW-1:0] rddata, rsp_data;
  logic [CW-1:0] credits;
`ifdef ESRAM_RD_ALIGN_CHECK_EN
  logic align_err;
`endif
  esram_rd_sched #(.AWIDTH(AW), .DWIDTH(DW), .MWIDTH(MW), .RD_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_esram(clk), .rst(rst), .esram_pll_lock(lock),
    .req_addr(req_addr), .req_meta(req_meta), .req_valid(req_valid), .req_ready(req_ready),
    .rden(rden), .rdaddress(rdaddress), .rd_valid(rd_valid), .rddata(rddata),
    .rsp_data(rsp_data), .rsp_meta(rsp_meta), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
`ifdef ESRAM_RD_ALIGN_CHECK_EN
    .align_err(align_err),
`endif
    .credits(credits));
  function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
    return {a ^ 17'h1abcd, {(DW-2*AW){1'b0}}, ~a};
  endfunction
  logic [LAT-1:0] pv = '0;
  logic [AW-1:0]  pa [LAT];
  always @(posedge clk) begin
    pv <= {pv[LAT-2:0], rden};
    pa[0] <= rdaddress;
    for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
  end
  assign rd_valid = pv[LAT-1] | inject;
  assign rddata   = mkdata(pa[LAT-1]);
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  typedef struct {logic [AW-1:0] a; logic [MW-1:0] m; int t;} ent_t;
  ent_t q[$];
  int cyc = 0, rden_cnt = 0, since_rst = 0;
  bit exp_rden = 0, rst_prev = 0, exp_align = 0;
  logic [AW-1:0] exp_addr = '0;
  always @(negedge clk) begin
    bit mready, mvalid, acc, pop;
    mready = lock && q.size() < DEPTH && !rst;
    mvalid = q.size() > 0 && q[0].t + LAT + 2 <= cyc;
    chk("req_ready", req_ready, mready);
    if (rst) begin
      if (rst_prev) begin
        chk("rst_rden", rden, 0);
        chk("rst_rdaddress", rdaddress, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_credits", credits, DEPTH);
      end
    end else begin
      chk("credits", credits, DEPTH - q.size());
      chk("rsp_valid", rsp_valid, mvalid);
      chk("rden", rden, exp_rden);
      if (exp_rden) chk("rdaddress", rdaddress, exp_addr);
      if (mvalid) begin
        chk("rsp_meta", rsp_meta, q[0].m);
        chk("rsp_data", rsp_data, mkdata(q[0].a));
      end
      if (rden) rden_cnt++;
    end
`ifdef ESRAM_RD_ALIGN_CHECK_EN
    if (!rst || rst_prev) chk("align_err", align_err, exp_align);
`endif
    if (rst) begin
      q.delete();
      exp_rden = 0;
      exp_align = 0;
      since_rst = 0;
    end else begin
      acc = req_valid && mready;
      pop = mvalid && rsp_ready;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{a: req_addr, m: req_meta, t: cyc});
      exp_rden = acc;
      exp_addr = req_addr;
      if (inject && since_rst >= LAT) exp_align = 1;
      since_rst++;
    end
    rst_prev = rst;
    cyc++;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic accept_n(input int n, output int got, output int k);
    got = 0;
    k = 0;
    req_valid = 1;
    while (got < n && k < 500) begin
      req_addr = AW'($urandom);
      req_meta = MW'($urandom);
      #1;
      if (req_ready) got++;
      step();
      k++;
    end
    req_valid = 0;
    chk("accept_count", got, n);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((credits != CW'(DEPTH) || rsp_valid) && n < 300) begin
      step();
      n++;
    end
    chk("idle_reached", n < 300, 1);
  endtask
  initial begin
    int n, got, k, c0, bad;
    rst = 1; lock = 1; req_valid = 0; req_addr = '0; req_meta = '0; rsp_ready = 1; inject = 0;
    repeat (3) step();
    rst = 0;
    step();
    req_valid = 1; req_addr = 17'h00010; req_meta = 16'h00AB;
    #1;
    chk("t1_ready", req_ready, 1);
    step();
    req_valid = 0;
    chk("t1_rden", rden, 1);
    chk("t1_rdaddress", rdaddress, 17'h00010);
    step();
    chk("t1_rden_pulse", rden, 0);
    n = 2;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
    chk("t1_latency", n, 14);
    chk("t1_meta", rsp_meta, 16'h00AB);
    wait_idle();
    c0 = rden_cnt;
    accept_n(64, got, k);
    chk("t2_cycles", k, 64);
    wait_idle();
    chk("t2_rden_count", rden_cnt - c0, 64);
    chk("t2_credits", credits, 32);
    rsp_ready = 0;
    req_valid = 1;
    got = 0;
    repeat (40) begin
      req_addr = AW'($urandom);
      req_meta = MW'($urandom);
      #1;
      if (req_ready) got++;
      step();
    end
    req_valid = 0;
    chk("t3_accepted", got, 32);
    chk("t3_credits", credits, 0);
    chk("t3_ready", req_ready, 0);
    repeat (20) step();
    rsp_ready = 1;
    wait_idle();
    rsp_ready = 0;
    accept_n(32, got, k);
    repeat (20) step();
    chk("t4_full", credits, 0);
    rsp_ready = 1;
    req_valid = 1;
    repeat (40) begin
      req_addr = AW'($urandom);
      req_meta = MW'($urandom);
      step();
    end
    req_valid = 0;
    wait_idle();
    lock = 0;
    req_valid = 1;
    repeat (5) begin
      #1;
      chk("t5_lock_ready", req_ready, 0);
      step();
    end
    req_valid = 0;
    lock = 1;
    c0 = rden_cnt;
    accept_n(5, got, k);
    lock = 0;
    req_valid = 1;
    repeat (20) step();
    req_valid = 0;
    chk("t5_rden_count", rden_cnt - c0, 5);
    chk("t5_delivered", q.size(), 0);
    lock = 1;
    wait_idle();
    accept_n(6, got, k);
    rst = 1;
    step();
    step();
    rst = 0;
    bad = 0;
    repeat (30) begin
      step();
      if (rsp_valid) bad++;
    end
    chk("t6_no_rsp", bad, 0);
`ifdef ESRAM_RD_ALIGN_CHECK_EN
    chk("t6_align_clean", align_err, 0);
    inject = 1;
    step();
    inject = 0;
    step();
    chk("t6_align_set", align_err, 1);
    rst = 1;
    step();
    step();
    rst = 0;
    step();
    chk("t6_align_clr", align_err, 0);
    repeat (LAT + 2) step();
`endif
    repeat (3000) begin
      req_valid = $urandom_range(0, 3) != 0;
      rsp_ready = $urandom_range(0, 2) != 0;
      lock = $urandom_range(0, 49) != 0;
      req_addr = AW'($urandom);
      req_meta = MW'($urandom);
      rst = $urandom_range(0, 999) == 0;
      step();
    end
    rst = 0; lock = 1; req_valid = 0; rsp_ready = 1;
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
